// File: rtl/pat_timer_bank.sv
// rtl/pat_timer_bank.sv - multi-channel prescaled timer bank with compare/match flags
// Optional capture inputs enabled by defining PAT_TIMER_CAPTURE_EN.
module pat_timer_bank #(
  parameter int D_WIDTH      = 8,
  parameter int N_CH         = 3,
  parameter int PRESC_WIDTH  = 8,
  parameter int CH_ADR_WIDTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_we,
  input  logic [CH_ADR_WIDTH-1:0] cfg_ch,
  input  logic [1:0]              cfg_sel,
  input  logic [D_WIDTH-1:0]      cfg_data,
  input  logic [N_CH-1:0]         flag_clr,
  input  logic [N_CH-1:0]         cap_in,
  output logic [N_CH*D_WIDTH-1:0] count_out,
  output logic [N_CH-1:0]         match_flag,
  output logic                    irq,
  output logic [N_CH*D_WIDTH-1:0] cap_out,
  output logic [N_CH-1:0]         cap_flag
);

  localparam logic [1:0] SEL_CTRL    = 2'd0;
  localparam logic [1:0] SEL_PRESC   = 2'd1;
  localparam logic [1:0] SEL_COMPARE = 2'd2;
  localparam logic [1:0] MODE_CLEAR  = 2'd1;
  localparam logic [1:0] MODE_ONE    = 2'd2;

  // Zero-extend (or truncate) write data to the prescaler width.
  logic [PRESC_WIDTH+D_WIDTH-1:0] presc_ext;
  logic [PRESC_WIDTH-1:0]         presc_wdata;
  assign presc_ext   = {{PRESC_WIDTH{1'b0}}, cfg_data};
  assign presc_wdata = presc_ext[PRESC_WIDTH-1:0];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic                   en;
    logic [1:0]             mode;
    logic [PRESC_WIDTH-1:0] prescale;
    logic [PRESC_WIDTH-1:0] presc_cnt;
    logic [D_WIDTH-1:0]     compare;
    logic [D_WIDTH-1:0]     count;
    logic                   flag;
    logic                   wr_ch;
    logic                   tick;
    logic                   hit;

    assign wr_ch = cfg_we && (cfg_ch == CH_ADR_WIDTH'(i));
    assign tick  = en && (presc_cnt == prescale);
    assign hit   = tick && (count == compare);

    always_ff @(posedge clk) begin
      if (reset) begin
        en        <= 1'b0;
        mode      <= 2'b00;
        prescale  <= '1;
        presc_cnt <= '0;
        compare   <= '1;
        count     <= '0;
        flag      <= 1'b0;
      end else begin
        if (!en || tick) presc_cnt <= '0;
        else             presc_cnt <= presc_cnt + 1'b1;

        if (hit) begin
          case (mode)
            MODE_CLEAR: count <= '0;
            MODE_ONE:   en    <= 1'b0;
            default:    count <= count + 1'b1;
          endcase
        end else if (tick) begin
          count <= count + 1'b1;
        end

        flag <= hit | (flag & ~flag_clr[i]);

        // Software writes come last so they override the hardware one-shot EN clear.
        if (wr_ch) begin
          case (cfg_sel)
            SEL_CTRL: begin
              en   <= cfg_data[0];
              mode <= cfg_data[2:1];
              if (!en && cfg_data[0]) begin
                count     <= '0;
                presc_cnt <= '0;
              end
            end
            SEL_PRESC: begin
              prescale  <= presc_wdata;
              presc_cnt <= '0;
            end
            SEL_COMPARE: compare <= cfg_data;
            default: ;
          endcase
        end
      end
    end

    assign count_out[i*D_WIDTH +: D_WIDTH] = count;
    assign match_flag[i]                   = flag;

`ifdef PAT_TIMER_CAPTURE_EN
    // cap_sync[1:0] is the synchroniser, cap_sync[2] the edge-detect history.
    logic [2:0]         cap_sync;
    logic               cap_edge;
    logic [D_WIDTH-1:0] cap_val;
    logic               cap_flg;

    assign cap_edge = cap_sync[1] & ~cap_sync[2];

    always_ff @(posedge clk) begin
      if (reset) begin
        cap_sync <= 3'b000;
        cap_val  <= '0;
        cap_flg  <= 1'b0;
      end else begin
        cap_sync <= {cap_sync[1:0], cap_in[i]};
        if (cap_edge) cap_val <= count;
        cap_flg <= cap_edge | (cap_flg & ~flag_clr[i]);
      end
    end

    assign cap_out[i*D_WIDTH +: D_WIDTH] = cap_val;
    assign cap_flag[i]                   = cap_flg;
`else
    assign cap_out[i*D_WIDTH +: D_WIDTH] = '0;
    assign cap_flag[i]                   = 1'b0;
`endif
  end

`ifdef PAT_TIMER_CAPTURE_EN
  logic unused_presc_bits;
  assign unused_presc_bits = ^presc_ext[PRESC_WIDTH+D_WIDTH-1:PRESC_WIDTH];
`else
  logic unused_inputs;
  assign unused_inputs = ^{cap_in, presc_ext[PRESC_WIDTH+D_WIDTH-1:PRESC_WIDTH]};
`endif

  always_ff @(posedge clk) begin
    if (reset) irq <= 1'b0;
    else       irq <= (|match_flag) | (|cap_flag);
  end

endmodule

// File: tb/tb_pat_timer_bank.sv
// tb/tb_pat_timer_bank.sv - directed scoreboard bench for pat_timer_bank
module tb_pat_timer_bank;
  localparam int DW = 8;
  localparam int NC = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [1:0]      cfg_ch;
  logic [1:0]      cfg_sel;
  logic [DW-1:0]   cfg_data;
  logic [NC-1:0]   flag_clr;
  logic [NC-1:0]   cap_in;
  logic [NC*DW-1:0] count_out;
  logic [NC-1:0]   match_flag;
  logic            irq;
  logic [NC*DW-1:0] cap_out;
  logic [NC-1:0]   cap_flag;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  string       tag_q[$];

  pat_timer_bank #(.D_WIDTH(DW), .N_CH(NC), .PRESC_WIDTH(8), .CH_ADR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .flag_clr(flag_clr), .cap_in(cap_in), .count_out(count_out),
    .match_flag(match_flag), .irq(irq), .cap_out(cap_out), .cap_flag(cap_flag)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic exp_push(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [63:0] obs);
    logic [63:0] e;
    string t;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  function automatic logic [DW-1:0] cnt(input int ch);
    return count_out[ch*DW +: DW];
  endfunction

  task automatic cfg(input int ch, input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_ch   = 2'(ch);
    cfg_sel  = 2'(sel);
    cfg_data = DW'(data);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_sel = '0; cfg_data = '0;
    flag_clr = '0; cap_in = '0;
    step(2);
    reset = 1'b0;

    // Reset state
    exp_push("rst_count", 64'h0);     chk(64'(count_out));
    exp_push("rst_flags", 64'h0);     chk(64'(match_flag));
    exp_push("rst_irq", 64'h0);       chk(64'(irq));
    exp_push("rst_capflag", 64'h0);   chk(64'(cap_flag));
    exp_push("rst_capout", 64'h0);    chk(64'(cap_out));

    // ch0 free-run, prescale 0, compare 5
    cfg(0, 1, 0); cfg(0, 2, 5); cfg(0, 0, 1);
    for (int k = 0; k <= 5; k++) begin
      exp_push($sformatf("c0_cnt%0d", k), 64'(k));
      exp_push($sformatf("c0_flag%0d", k), 64'h0);
      chk(64'(cnt(0))); chk(64'(match_flag[0]));
      step();
    end
    exp_push("c0_cnt6", 64'd6);   chk(64'(cnt(0)));
    exp_push("c0_match", 64'h1);  chk(64'(match_flag[0]));
    exp_push("c0_irq_lag", 64'h0); chk(64'(irq));
    step();
    exp_push("c0_irq", 64'h1);    chk(64'(irq));
    exp_push("c0_cnt7", 64'd7);   chk(64'(cnt(0)));

    // ch1 prescale 3, compare 255, wrap and continuous clear
    do_reset();
    cfg(1, 1, 3); cfg(1, 2, 255); cfg(1, 0, 1);
    step(3);
    exp_push("c1_presc_hold", 64'h0); chk(64'(cnt(1)));
    step();
    exp_push("c1_presc_tick", 64'h1); chk(64'(cnt(1)));
    step(1016);
    exp_push("c1_cnt255", 64'd255); chk(64'(cnt(1)));
    exp_push("c1_noflag", 64'h0);   chk(64'(match_flag[1]));
    step(4);
    exp_push("c1_wrap0", 64'h0);    chk(64'(cnt(1)));
    exp_push("c1_flag", 64'h1);     chk(64'(match_flag[1]));
    flag_clr[1] = 1'b1;
    step();
    exp_push("c1_cleared", 64'h0);  chk(64'(match_flag[1]));
    cfg(1, 2, 2);
    step(9);
    exp_push("c1_pre_match_cnt", 64'd2); chk(64'(cnt(1)));
    exp_push("c1_pre_match_flag", 64'h0); chk(64'(match_flag[1]));
    step();
    exp_push("c1_reassert", 64'h1); chk(64'(match_flag[1]));
    exp_push("c1_cnt3", 64'd3);     chk(64'(cnt(1)));
    flag_clr[1] = 1'b0;
    step();
    exp_push("c1_irq", 64'h1);      chk(64'(irq));

    // ch2 clear-on-match, compare 2
    do_reset();
    cfg(2, 1, 0); cfg(2, 2, 2); cfg(2, 0, 3);
    step(2);
    exp_push("c2_cnt2", 64'd2);  chk(64'(cnt(2)));
    step();
    exp_push("c2_clr0", 64'd0);  chk(64'(cnt(2)));
    exp_push("c2_flag", 64'h1);  chk(64'(match_flag[2]));
    step();
    flag_clr[2] = 1'b1;
    step();
    exp_push("c2_flag_clr", 64'h0); chk(64'(match_flag[2]));
    step();
    exp_push("c2_set_wins", 64'h1); chk(64'(match_flag[2]));
    exp_push("c2_cnt0b", 64'd0);    chk(64'(cnt(2)));
    flag_clr[2] = 1'b0;

    // ch0 one-shot, compare 3, then restart
    do_reset();
    cfg(0, 1, 0); cfg(0, 2, 3); cfg(0, 0, 5);
    step(3);
    exp_push("os_cnt3", 64'd3);  chk(64'(cnt(0)));
    step(3);
    exp_push("os_hold", 64'd3);  chk(64'(cnt(0)));
    exp_push("os_flag", 64'h1);  chk(64'(match_flag[0]));
    cfg(0, 0, 0);
    exp_push("os_off_hold", 64'd3); chk(64'(cnt(0)));
    cfg(0, 0, 5);
    exp_push("os_restart0", 64'd0); chk(64'(cnt(0)));
    step();
    exp_push("os_restart1", 64'd1); chk(64'(cnt(0)));

    // Mid-run reset, reserved select and out-of-range channel writes
    do_reset();
    cfg(0, 1, 0); cfg(0, 2, 3); cfg(0, 0, 1);
    step(7);
    exp_push("mr_cnt7", 64'd7);  chk(64'(cnt(0)));
    exp_push("mr_irq", 64'h1);   chk(64'(irq));
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_push("mr_count", 64'h0); chk(64'(count_out));
    exp_push("mr_flags", 64'h0); chk(64'(match_flag));
    exp_push("mr_irq0", 64'h0);  chk(64'(irq));
    cfg(3, 1, 0); cfg(3, 2, 0); cfg(3, 0, 1); cfg(0, 3, 8'hff);
    step(5);
    exp_push("ch3_count", 64'h0); chk(64'(count_out));
    exp_push("ch3_flags", 64'h0); chk(64'(match_flag));

`ifdef PAT_TIMER_CAPTURE_EN
    do_reset();
    cfg(0, 1, 0); cfg(0, 0, 1);
    step(4);
    exp_push("cap_base", 64'd4); chk(64'(cnt(0)));
    cap_in[0] = 1'b1;
    step(2);
    exp_push("cap_flag_early", 64'h0); chk(64'(cap_flag[0]));
    step();
    exp_push("cap_flag", 64'h1);  chk(64'(cap_flag[0]));
    exp_push("cap_out", 64'd6);   chk(64'(cap_out[DW-1:0]));
    step();
    exp_push("cap_irq", 64'h1);   chk(64'(irq));
`else
    cap_in = '1;
    step(5);
    exp_push("nocap_flag", 64'h0); chk(64'(cap_flag));
    exp_push("nocap_out", 64'h0);  chk(64'(cap_out));
    exp_push("nocap_irq", 64'h0);  chk(64'(irq));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pat_timer_bank.md
Name: pat_timer_bank

Overview:
Parametrised multi-channel timer peripheral for the PAT digital top. It replaces the fixed 8-bit timer with its hard-wired divide-by-256 prescaler.
- Provides N_CH independent channels. Each channel has a programmable prescaler, a compare value, a sticky match flag and free-run / clear-on-match / one-shot modes.
- Count values feed PAT input ports. Match flags and irq feed the control/status input port.

Parameters:
D_WIDTH, 8, counter, compare and config data width
N_CH, 3, number of timer channels
PRESC_WIDTH, 8, prescaler register width
CH_ADR_WIDTH, 2, channel select width; must satisfy 2**CH_ADR_WIDTH >= N_CH

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
cfg_we  input  1  config write strobe, one write per cycle
cfg_ch  input  CH_ADR_WIDTH  target channel; writes to a channel >= N_CH are ignored
cfg_sel  input  2  register select: 0=ctrl, 1=prescale, 2=compare, 3=reserved (write ignored)
cfg_data  input  D_WIDTH  write data; prescale uses the low PRESC_WIDTH bits, zero-extended if PRESC_WIDTH > D_WIDTH
flag_clr  input  N_CH  per-channel match-flag clear, level-sampled each cycle
cap_in  input  N_CH  asynchronous capture inputs (optional feature)
count_out  output  N_CH*D_WIDTH  registered counts; channel i occupies bits [i*D_WIDTH +: D_WIDTH]
match_flag  output  N_CH  sticky match flags
irq  output  1  registered OR of all match_flag bits, plus cap_flag bits when the optional feature is enabled
cap_out  output  N_CH*D_WIDTH  captured counts (optional feature)
cap_flag  output  N_CH  sticky capture flags (optional feature)

Behaviour:
- Reset (synchronous, active-high, clk):
  - Every channel: ctrl=0 (disabled), prescale=all ones, presc_cnt=0, compare=all ones, count=0.
  - match_flag=0, cap_flag=0, cap_out=0, irq=0.
  - Reset mid-count aborts immediately; nothing survives.
- ctrl bits:
  - [0] EN.
  - [2:1] MODE: 0=free-run, 1=clear-on-match, 2=one-shot, 3 treated as free-run.
  - Higher bits are ignored. Readback is not provided.
- Prescaler, per channel:
  - While EN=1, presc_cnt increments every clk.
  - When presc_cnt==prescale, a tick is asserted that cycle and presc_cnt wraps to 0.
  - prescale=0 gives a tick every cycle. prescale=P gives period P+1.
  - EN=0 holds presc_cnt at 0.
- Counter, on a tick:
  - If count==compare:
    - match_flag is set.
    - free-run: count+1 with modulo 2**D_WIDTH wrap.
    - clear-on-match: count<=0.
    - one-shot: count holds and EN is cleared by hardware.
  - Otherwise count<=count+1, wrapping all-ones to 0 in every mode.
  - Wrap itself never sets match_flag.
  - count_out reflects the new value one cycle after the tick edge.
- Config writes take effect at the write edge; the new values are used from the next cycle on.
  - Writing prescale also clears presc_cnt to 0.
  - Writing ctrl with EN=1 does not clear count. To restart, write ctrl EN=0 and then EN=1; the EN 0->1 transition clears count and presc_cnt.
  - Writing compare while running is allowed. A value already passed matches only after the counter wraps.
- Same-cycle conflicts:
  - Set and clear of a flag in the same cycle: set wins.
  - Hardware EN-clear (one-shot) and a software ctrl write in the same cycle: the software write wins.
- irq is registered, so it lags the flags by 1 cycle.

Optional Feature:
PAT_TIMER_CAPTURE_EN
- Defined:
  - Each cap_in bit passes through a 2-flop synchroniser and a rising-edge detector.
  - On a detected edge, cap_out[i] <= count of channel i (the value before any same-cycle tick update) and cap_flag[i] is set.
  - flag_clr[i] also clears cap_flag[i]; set wins on a same-cycle conflict.
  - Edge-to-flag latency is 3 cycles from the cap_in change.
- Undefined:
  - cap_in is ignored; cap_out and cap_flag are tied to 0.
  - irq covers match_flag only.

Test Plan:
- Reset, then ch0 ctrl=1, prescale=0, compare=5 -> count_out ch0 steps 0,1,2..., match_flag[0] rises on the cycle count reaches 6 (after 5==compare tick); irq 1 cycle later.
- ch1 prescale=3, ctrl=1 (free-run), compare=255 -> count increments every 4 clks; 255 sets the flag then wraps to 0; with flag_clr[1] held continuously the flag reasserts at the next match.
- ch2 MODE=clear-on-match, compare=2, prescale=0 -> counts 0,1,2,0,1,2...; flag set each match; flag_clr on a match cycle -> flag stays 1.
- ch0 MODE=one-shot (ctrl=5), compare=3 -> count stops at 3, EN auto-clears; writing ctrl=0 then ctrl=5 restarts from 0.
- Mid-run reset pulse at count=7 -> all counts, flags and irq are 0 on the next cycle; cfg writes to cfg_ch=3 with N_CH=3 change nothing.
- With PAT_TIMER_CAPTURE_EN, ch0 free-run with prescale=0, cap_in[0] rising at a known cycle -> cap_out ch0 equals the count 2 cycles later (pre-update), and cap_flag[0] plus irq assert.
